spi_master_gen: RTL
===================

SPI_MASTER_GEN -- requirements
Module: spi_master_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, frame width in bits (>=2).
REQ-002 SHALL have parameter DIV, default 4, SCLK half-period in mclk cycles (>=1).
REQ-003 SHALL have parameter NUM_CS, default 1, number of chip selects (1..8).
REQ-004 SHALL have port mclk  input  1  sole clock; all state on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port load  input  1  capture data_in into TX holding register.
REQ-007 SHALL have port data_in  input  DATA_W  TX word.
REQ-008 SHALL have port start  input  1  begin frame (level, sampled in IDLE).
REQ-009 SHALL have port cpol  input  1  SCLK idle level.
REQ-010 SHALL have port cpha  input  1  0: sample leading edge; 1: sample trailing edge.
REQ-011 SHALL have port lsb_first  input  1  bit order select.
REQ-012 SHALL have port cs_sel  input  CS_W  target select, CS_W = max(1, clog2(NUM_CS)).
REQ-013 SHALL have port read  input  1  acknowledge/consume RX word.
REQ-014 SHALL have port data_out  output  DATA_W  last received word.
REQ-015 SHALL have port rx_valid  output  1  unread RX word present.
REQ-016 SHALL have port overrun  output  1  sticky: frame completed while rx_valid set.
REQ-017 SHALL have port busy  output  1  frame in progress.
REQ-018 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-019 SHALL have ports sclk  output  1; mosi  output  1; miso  input  1; cs_n  output  NUM_CS (active-low).

Function
REQ-020 FSM SHALL have states IDLE, SETUP, SHIFT, HOLD; IDLE->SETUP on start; SETUP->SHIFT after DIV cycles; SHIFT->HOLD after DATA_W bits; HOLD->IDLE after DIV cycles.
REQ-021 On IDLE->SETUP, cpol, cpha, lsb_first, cs_sel and TX holding word SHALL be latched; mid-frame changes SHALL have no effect.
REQ-022 busy SHALL be 1 in SETUP/SHIFT/HOLD; start while busy SHALL be ignored.
REQ-023 cs_n[cs_sel] SHALL be 0 in SETUP/SHIFT/HOLD, all other bits 1; cs_sel >= NUM_CS SHALL abort start (no frame, no done).
REQ-024 sclk SHALL equal latched cpol outside SHIFT and toggle every DIV cycles in SHIFT, giving 2*DATA_W edges.
REQ-025 cpha=0: first bit SHALL be on mosi on SETUP entry; sample miso on leading edges, shift mosi on trailing edges.
REQ-026 cpha=1: mosi SHALL shift on leading edges, miso sampled on trailing edges.
REQ-027 Bit order SHALL be MSB-first when lsb_first=0, LSB-first otherwise, for both TX and RX.
REQ-028 done SHALL pulse in the cycle of HOLD->IDLE, exactly 2*DIV*(DATA_W+1) cycles after busy rises; busy falls the same cycle.
REQ-029 At done, data_out SHALL update and rx_valid SHALL set; if rx_valid was already 1 and read not asserted that cycle, overrun SHALL set.
REQ-030 read SHALL clear rx_valid and overrun; read coincident with done SHALL leave rx_valid=1 and overrun unchanged.
REQ-031 load SHALL be accepted in any state (double-buffered); load while busy SHALL affect only the next frame.
REQ-032 start and load in the same IDLE cycle SHALL transmit the new data_in.
REQ-033 mosi SHALL be 0 when not busy.

Reset
REQ-034 reset SHALL force IDLE, sclk=0, mosi=0, cs_n all 1, busy=0, done=0, rx_valid=0, overrun=0, data_out=0, TX holding=0.
REQ-035 reset mid-frame SHALL abort immediately with no done pulse; first start after release SHALL run a full frame.

Structure
REQ-036 Package spi_pkg SHALL hold the state enum typedef, DATA_W/DIV defaults and CS_W helper function.
REQ-037 Sub-module spi_clk_gen SHALL generate DIV-based edge strobes (leading/trailing) and sclk.

Verification
REQ-038 DATA_W=8, DIV=2, mode 0, MSB-first, load 0xA5, miso looped to mosi -> data_out=0xA5, done 36 cycles after busy rises.
REQ-039 Modes 1/2/3 with slave model returning 0x3C -> data_out=0x3C, sclk idle = cpol each mode.
REQ-040 lsb_first=1, TX 0x01 -> first mosi bit 1, then seven 0s.
REQ-041 Two frames without read -> second done sets overrun=1; read -> rx_valid=0, overrun=0.
REQ-042 reset asserted at bit 4 -> cs_n all 1, busy=0, no done; next frame 0x5A completes correctly.
REQ-043 NUM_CS=4, cs_sel=2 -> cs_n=4'b1011 for frame; start while busy ignored.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types, defaults and helpers for the SPI master block.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DIV    = 4;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: emits leading/trailing edge strobes every DIV mclk cycles while enabled.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic mclk,
  input  logic reset,
  input  logic en,
  input  logic cpol,
  output logic lead,
  output logic trail,
  output logic sclk
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;
  logic          tog;
  logic          hit;

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      tog <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tog <= 1'b0;
    end else if (hit) begin
      cnt <= '0;
      tog <= ~tog;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // tog is 0 between edge pairs, so sclk sits at cpol whenever the divider is idle
  always_comb begin
    hit   = en && (cnt == CW'(DIV - 1));
    lead  = hit && !tog;
    trail = hit && tog;
    sclk  = cpol ^ tog;
  end

endmodule

// File: rtl/spi_master_gen.sv
// Generic SPI master: double-buffered TX, all four modes, selectable bit order and chip select.
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DIV    = DEF_DIV,
  parameter int NUM_CS = 1,
  localparam int CS_W  = cs_width(NUM_CS)
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              read,
  output logic [DATA_W-1:0] data_out,
  output logic              rx_valid,
  output logic              overrun,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(DATA_W);

  state_t            state, nxt;
  logic [DW-1:0]     dcnt;
  logic [BW-1:0]     bcnt;
  logic [DATA_W-1:0] tx_hold, tx_sh, rx_sh, word;
  logic              cpol_l, cpha_l, lsb_l;
  logic [CS_W-1:0]   cs_l;
  logic              mosi_r;
  logic              lead, trail, shift_ev, sample_ev;
  logic              go, dly_end, last_bit, frame_end;

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  spi_clk_gen #(.DIV(DIV)) u_clk (
    .mclk  (mclk),
    .reset (reset),
    .en    (state == SHIFT),
    .cpol  (cpol_l),
    .lead  (lead),
    .trail (trail),
    .sclk  (sclk)
  );

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    go        = start && (int'(cs_sel) < NUM_CS);
    dly_end   = (dcnt == DW'(DIV - 1));
    last_bit  = trail && (bcnt == BW'(DATA_W - 1));
    shift_ev  = cpha_l ? lead : trail;
    sample_ev = cpha_l ? trail : lead;
    word      = load ? data_in : tx_hold;
    nxt       = state;
    case (state)
      IDLE:    if (go)       nxt = SETUP;
      SETUP:   if (dly_end)  nxt = SHIFT;
      SHIFT:   if (last_bit) nxt = HOLD;
      HOLD:    if (dly_end)  nxt = IDLE;
      default:               nxt = IDLE;
    endcase
    frame_end = (state == HOLD) && dly_end;
    busy      = (state != IDLE);
    mosi      = busy && mosi_r;
    cs_n      = '1;
    for (int unsigned i = 0; i < NUM_CS; i++)
      cs_n[i] = !(busy && (cs_l == CS_W'(i)));
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      tx_hold  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      data_out <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      done     <= 1'b0;
      mosi_r   <= 1'b0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      lsb_l    <= 1'b0;
      cs_l     <= '0;
      dcnt     <= '0;
      bcnt     <= '0;
    end else begin
      if (load) tx_hold <= data_in;
      done <= frame_end;

      if ((state == SETUP) || (state == HOLD))
        dcnt <= dly_end ? '0 : dcnt + 1'b1;
      if (trail) bcnt <= bcnt + 1'b1;

      if (shift_ev) begin
        mosi_r <= first_bit(tx_sh, lsb_l);
        tx_sh  <= shift_out(tx_sh, lsb_l);
      end
      if (sample_ev)
        rx_sh <= lsb_l ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};

      // mode 0 presents its first bit at SETUP entry; mode 1 waits for the first leading edge
      if ((state == IDLE) && go) begin
        cpol_l <= cpol;
        cpha_l <= cpha;
        lsb_l  <= lsb_first;
        cs_l   <= cs_sel;
        dcnt   <= '0;
        bcnt   <= '0;
        if (cpha) begin
          mosi_r <= 1'b0;
          tx_sh  <= word;
        end else begin
          mosi_r <= first_bit(word, lsb_first);
          tx_sh  <= shift_out(word, lsb_first);
        end
      end

      if (frame_end) begin
        data_out <= rx_sh;
        rx_valid <= 1'b1;
        if (rx_valid && !read) overrun <= 1'b1;
      end else if (read) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end
    end
  end

endmodule
